// File: rtl/poly_sequencer_if.sv
// Control bundle between the polynomial sequencer and its datapath.
// Carries the operand strobe plus all load, mux and status lines.
interface poly_sequencer_if;
    logic       go;
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_x;
    logic       ld_r;
    logic       ld_alu_out;
    logic [1:0] alu_select_a;
    logic [1:0] alu_select_b;
    logic       alu_op;
    logic       busy;
    logic       done;

    modport master (
        output go,
        input  ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
        input  alu_select_a, alu_select_b, alu_op, busy, done
    );

    modport slave (
        input  go,
        output ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
        output alu_select_a, alu_select_b, alu_op, busy, done
    );
endinterface

// File: rtl/poly_sequencer.sv
// Moore FSM sequencing the shared ALU datapath for R = A*X^2 + B*X + C.
// Collects four operands via go press/release, then runs five ALU steps.
module poly_sequencer (
    input  logic            i_clk,
    input  logic            i_reset,
    poly_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        S_LOAD_A      = 4'd0,
        S_LOAD_A_WAIT = 4'd1,
        S_LOAD_B      = 4'd2,
        S_LOAD_B_WAIT = 4'd3,
        S_LOAD_C      = 4'd4,
        S_LOAD_C_WAIT = 4'd5,
        S_LOAD_X      = 4'd6,
        S_LOAD_X_WAIT = 4'd7,
        S_MUL0        = 4'd8,
        S_MUL1        = 4'd9,
        S_MUL2        = 4'd10,
        S_SUM1        = 4'd11,
        S_SUM2        = 4'd12,
        S_DONE        = 4'd13
    } state_t;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_LOAD_A;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next           = S_LOAD_A;
        bus.ld_a         = 1'b0;
        bus.ld_b         = 1'b0;
        bus.ld_c         = 1'b0;
        bus.ld_x         = 1'b0;
        bus.ld_r         = 1'b0;
        bus.ld_alu_out   = 1'b0;
        bus.alu_select_a = SEL_A;
        bus.alu_select_b = SEL_A;
        bus.alu_op       = 1'b0;
        bus.busy         = 1'b0;
        bus.done         = 1'b0;
        case (r_state)
            S_LOAD_A: begin
                bus.ld_a = 1'b1;
                w_next   = bus.go ? S_LOAD_A_WAIT : S_LOAD_A;
            end
            S_LOAD_A_WAIT: w_next = bus.go ? S_LOAD_A_WAIT : S_LOAD_B;
            S_LOAD_B: begin
                bus.ld_b = 1'b1;
                w_next   = bus.go ? S_LOAD_B_WAIT : S_LOAD_B;
            end
            S_LOAD_B_WAIT: w_next = bus.go ? S_LOAD_B_WAIT : S_LOAD_C;
            S_LOAD_C: begin
                bus.ld_c = 1'b1;
                w_next   = bus.go ? S_LOAD_C_WAIT : S_LOAD_C;
            end
            S_LOAD_C_WAIT: w_next = bus.go ? S_LOAD_C_WAIT : S_LOAD_X;
            S_LOAD_X: begin
                bus.ld_x = 1'b1;
                w_next   = bus.go ? S_LOAD_X_WAIT : S_LOAD_X;
            end
            S_LOAD_X_WAIT: w_next = bus.go ? S_LOAD_X_WAIT : S_MUL0;
            // A*X twice builds A*X^2 in place
            S_MUL0, S_MUL1: begin
                bus.ld_a         = 1'b1;
                bus.ld_alu_out   = 1'b1;
                bus.alu_select_a = SEL_A;
                bus.alu_select_b = SEL_X;
                bus.alu_op       = 1'b1;
                bus.busy         = 1'b1;
                w_next           = (r_state == S_MUL0) ? S_MUL1 : S_MUL2;
            end
            S_MUL2: begin
                bus.ld_b         = 1'b1;
                bus.ld_alu_out   = 1'b1;
                bus.alu_select_a = SEL_B;
                bus.alu_select_b = SEL_X;
                bus.alu_op       = 1'b1;
                bus.busy         = 1'b1;
                w_next           = S_SUM1;
            end
            S_SUM1: begin
                bus.ld_a         = 1'b1;
                bus.ld_alu_out   = 1'b1;
                bus.alu_select_a = SEL_A;
                bus.alu_select_b = SEL_B;
                bus.busy         = 1'b1;
                w_next           = S_SUM2;
            end
            S_SUM2: begin
                bus.ld_r         = 1'b1;
                bus.alu_select_a = SEL_A;
                bus.alu_select_b = SEL_C;
                bus.busy         = 1'b1;
                w_next           = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                w_next   = S_LOAD_A;
            end
            default: w_next = S_LOAD_A;
        endcase
    end
endmodule

// File: tb/tb_poly_sequencer.sv
// Directed bench: poly_sequencer driving a behavioural copy of the datapath.
// Checks control outputs cycle by cycle and the final R value.
module tb_poly_sequencer;
    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [7:0] ra, rb, rc, rx, rr;
    logic [7:0] opa, opb, alu;
    logic [12:0] ctl;
    int ncmp;
    int nerr;

    poly_sequencer_if bus();

    poly_sequencer dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    pick = ra;
            2'd1:    pick = rb;
            2'd2:    pick = rc;
            default: pick = rx;
        endcase
    endfunction

    always_comb begin
        opa = pick(bus.alu_select_a);
        opb = pick(bus.alu_select_b);
        alu = bus.alu_op ? 8'(opa * opb) : 8'(opa + opb);
    end

    always @(posedge clk) begin
        if (rst) begin
            ra <= 8'd0; rb <= 8'd0; rc <= 8'd0; rx <= 8'd0; rr <= 8'd0;
        end else begin
            if (bus.ld_a) ra <= bus.ld_alu_out ? alu : data_in;
            if (bus.ld_b) rb <= bus.ld_alu_out ? alu : data_in;
            if (bus.ld_c) rc <= data_in;
            if (bus.ld_x) rx <= data_in;
            if (bus.ld_r) rr <= alu;
        end
    end

    assign ctl = {bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_x, bus.ld_r,
                  bus.ld_alu_out, bus.alu_select_a, bus.alu_select_b,
                  bus.alu_op, bus.busy, bus.done};

    // {ld_a,ld_b,ld_c,ld_x,ld_r,ld_alu_out,sel_a,sel_b,op,busy,done}
    localparam logic [12:0] C_LA   = 13'b1_0_0_0_0_0_00_00_0_0_0;
    localparam logic [12:0] C_WAIT = 13'b0_0_0_0_0_0_00_00_0_0_0;

    function automatic logic [12:0] comp_row(input int i);
        case (i)
            0, 1:    comp_row = 13'b1_0_0_0_0_1_00_11_1_1_0;
            2:       comp_row = 13'b0_1_0_0_0_1_01_11_1_1_0;
            3:       comp_row = 13'b1_0_0_0_0_1_00_01_0_1_0;
            4:       comp_row = 13'b0_0_0_0_1_0_00_10_0_1_0;
            default: comp_row = 13'b0_0_0_0_0_0_00_00_0_0_1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load_op(input int idx, input logic [7:0] v);
        logic [12:0] one;
        one = C_LA >> idx;
        @(negedge clk);
        chk($sformatf("load%0d_state", idx), 32'(ctl), 32'(one));
        bus.go  = 1'b1;
        data_in = v;
        @(negedge clk);
        chk($sformatf("load%0d_wait", idx), 32'(ctl), 32'(C_WAIT));
        bus.go = 1'b0;
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] x);
        load_op(0, a);
        load_op(1, b);
        load_op(2, c);
        load_op(3, x);
    endtask

    task automatic compute(input string tag, input logic [7:0] exp_r);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("%s_step%0d", tag, c), 32'(ctl), 32'(comp_row(c)));
        end
        chk($sformatf("%s_R", tag), 32'(rr), 32'(exp_r));
    endtask

    typedef struct {
        logic [7:0] a, b, c, x, r;
        string      nm;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{8'd2,  8'd3, 8'd4,   8'd5,   8'd69,  "basic"};
        vecs[1] = '{8'd10, 8'd0, 8'd0,   8'd10,  8'd232, "wrap_sq"};
        vecs[2] = '{8'd0,  8'd0, 8'd255, 8'd7,   8'd255, "c_only"};
        vecs[3] = '{8'd3,  8'd7, 8'd9,   8'd200, 8'd65,  "wrap_mix"};
        ncmp    = 0;
        nerr    = 0;
        rst     = 1'b1;
        bus.go  = 1'b0;
        data_in = 8'd0;

        repeat (2) @(negedge clk);
        chk("reset_during", 32'(ctl), 32'(C_LA));
        rst = 1'b0;
        @(negedge clk);
        chk("reset_after", 32'(ctl), 32'(C_LA));

        // Back-to-back evaluations straight from the table
        foreach (vecs[i]) begin
            load4(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].x);
            compute(vecs[i].nm, vecs[i].r);
        end

        // go held high in B's wait state: B captured once, next value to C
        load_op(0, 8'd5);
        @(negedge clk);
        chk("held_ldb", 32'(ctl), 32'(C_LA >> 1));
        bus.go  = 1'b1;
        data_in = 8'd6;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("held_wait%0d", i), 32'(ctl), 32'(C_WAIT));
            data_in = 8'd99;
        end
        bus.go = 1'b0;
        chk("held_b", 32'(rb), 32'd6);
        load_op(2, 8'd7);
        load_op(3, 8'd2);
        chk("held_c", 32'(rc), 32'd7);
        compute("held", 8'd39);

        // go raised in S_DONE: LOAD_A still occupied for one cycle
        bus.go  = 1'b1;
        data_in = 8'd8;
        @(negedge clk);
        chk("done_go_lda", 32'(ctl), 32'(C_LA));
        @(negedge clk);
        chk("done_go_wait", 32'(ctl), 32'(C_WAIT));
        bus.go = 1'b0;
        load_op(1, 8'd1);
        load_op(2, 8'd1);
        load_op(3, 8'd3);
        compute("done_go", 8'd76);

        // Reset in the middle of the compute phase
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort_step%0d", c), 32'(ctl), 32'(comp_row(c)));
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort_reset", 32'(ctl), 32'(C_LA));
        rst = 1'b0;
        load4(8'd1, 8'd1, 8'd1, 8'd1);
        compute("after_abort", 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
